pc_gen: RTL



---
 rtl/pc_pkg.sv | 18 +
 rtl/ras_stack.sv | 69 ++++++
 rtl/pc_gen.sv | 98 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_TRAP,
    SEL_HOLD,
    SEL_RET,
    SEL_REDIR,
    SEL_SEQ
  } pc_sel_e;

  // Pointer width for a RAS of the given depth; never narrower than one bit.
  function automatic int ras_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ras_stack
  import pc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             underflow
);

  localparam int PW = ras_ptr_w(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    sp, sp_nxt, top_idx;
  logic [CW-1:0]    count, cnt_nxt;
  logic             do_pop;

  // sp points at the next free slot; wrapping relies on RAS_DEPTH being a power of two.
  assign top_idx = sp - PW'(1);
  assign top     = mem[top_idx];
  assign do_pop  = pop & ~empty;

  always_comb begin
    sp_nxt  = sp;
    cnt_nxt = count;
    if (push && !do_pop) begin
      sp_nxt = sp + PW'(1);
      if (count != DEPTH_C) cnt_nxt = count + CW'(1);
    end else if (do_pop && !push) begin
      sp_nxt  = sp - PW'(1);
      cnt_nxt = count - CW'(1);
    end
  end

  // Push+pop on a non-empty stack replaces the top entry in place.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      if (do_pop) mem[top_idx] <= push_data;
      else        mem[sp]      <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      count     <= cnt_nxt;
      empty     <= (cnt_nxt == '0);
      full      <= (cnt_nxt == DEPTH_C);
      underflow <= pop & empty;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: trap vectoring, stall with held redirects, and RAS return prediction.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH           = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR    = WIDTH'(32'h0040_0000),
  parameter logic [WIDTH-1:0] TRAP_VECTOR     = WIDTH'(32'h8000_0180),
  parameter int               INCR            = 4,
  parameter int               RAS_DEPTH       = 8,
  parameter bit               LEGACY_REDIRECT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             link_push,
  input  logic             ret_pop,
  input  logic             trap,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] link_addr,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);

  localparam logic [WIDTH-1:0] INCR_C = WIDTH'(INCR);

  logic [WIDTH-1:0] pend_pc, redir_tgt, pc_nxt, ras_top;
  logic             pend_valid, ras_push, ras_pop;
  pc_sel_e          sel;

  assign link_addr = pc + INCR_C;

  // The RAS only moves on cycles that actually advance the PC.
  assign ras_push = link_push & ~stall & ~trap;
  assign ras_pop  = ret_pop & ~stall & ~trap;

  ras_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .underflow (ras_underflow)
  );

  assign redir_tgt = redirect_valid ? redirect_pc : pend_pc;

  always_comb begin
    sel = SEL_SEQ;
    if (rst)                                sel = SEL_RESET;
    else if (trap)                          sel = SEL_TRAP;
    else if (stall)                         sel = SEL_HOLD;
    else if (ret_pop && !ras_empty)         sel = SEL_RET;
    else if (redirect_valid || pend_valid)  sel = SEL_REDIR;
  end

  always_comb begin
    pc_nxt = pc + INCR_C;
    case (sel)
      SEL_RESET: pc_nxt = RESET_VECTOR;
      SEL_TRAP:  pc_nxt = TRAP_VECTOR;
      SEL_HOLD:  pc_nxt = pc;
      SEL_RET:   pc_nxt = ras_top;
      SEL_REDIR: pc_nxt = LEGACY_REDIRECT ? redir_tgt + INCR_C : redir_tgt;
      default:   pc_nxt = pc + INCR_C;
    endcase
  end

  // Pending redirect survives only while stalled; any unstalled cycle consumes or discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_VECTOR;
      epc        <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      pc <= pc_nxt;
      if (trap) begin
        epc        <= pc;
        pend_valid <= 1'b0;
      end else if (stall) begin
        if (redirect_valid) begin
          pend_valid <= 1'b1;
          pend_pc    <= redirect_pc;
        end
      end else begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
